// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared types for the ALU adder datapath.
//   alu_op_e    : operation select carried on the 'sub' wire (ADD / SUB)
//   alu_flags_t : status flags produced alongside the result
//   split_ok()  : elaboration-time check that a WIDTH-bit add divides evenly
//                 into STAGES slices
// ---------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic {
        ALU_ADD = 1'b0,
        ALU_SUB = 1'b1
    } alu_op_e;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
    } alu_flags_t;

    function automatic bit split_ok(int width, int stages);
        return (stages >= 1) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_slice.sv
// ---------------------------------------------------------------------------
// adder_slice
// Purely combinational CHUNK-bit adder with carry in and carry out; one of
// these sits in each pipeline stage of pipe_adder.
//   a_i, b_i : CHUNK-bit operand chunks (b_i already inverted for SUB)
//   c_i      : carry into the chunk
//   s_o      : CHUNK-bit partial sum
//   c_o      : carry out of the chunk MSB
// ---------------------------------------------------------------------------
module adder_slice #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             c_i,
    output logic [CHUNK-1:0] s_o,
    output logic             c_o
);

    logic [CHUNK:0] total;

    // One extra bit on the left captures the chunk carry-out.
    assign total     = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, c_i};
    assign {c_o, s_o} = total;

endmodule

// File: rtl/pipe_adder.sv
// ---------------------------------------------------------------------------
// pipe_adder
// Pipelined WIDTH-bit adder/subtractor. The add is split into STAGES slices
// of CHUNK = WIDTH/STAGES bits; stage k adds chunk k and registers its
// partial result, its carry, and the operands for the stages still to come.
// One operation per cycle under valid/ready; the whole pipe stalls as one
// when the result is not taken.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (in_ready = !stall)
//   a, b, cin, sub      : operands, carry-in (ADD only), 1 = subtract
//   out_valid/out_ready : result handshake
//   sum, cout, ovf, zero: result and flags, held while stalled
// ---------------------------------------------------------------------------
module pipe_adder
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int  CHUNK    = WIDTH / STAGES;
    localparam int  MSB      = WIDTH - 1;
    localparam bit  SPLIT_OK = split_ok(WIDTH, STAGES);

    if (!SPLIT_OK) begin : g_bad_split
        $error("pipe_adder: WIDTH must be a positive multiple of STAGES");
    end

    // Stage registers. a_q/bp_q carry the operands forward (skew) so later
    // stages see the chunks of the operation they are working on.
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] bp_q    [STAGES];
    logic [WIDTH-1:0] sum_q   [STAGES];
    logic             carry_q [STAGES];
    logic             valid_q [STAGES];
    alu_flags_t       flags_q;

    // What each stage sees at its input this cycle.
    logic [WIDTH-1:0] a_src   [STAGES];
    logic [WIDTH-1:0] bp_src  [STAGES];
    logic [WIDTH-1:0] sum_src [STAGES];
    logic             c_src   [STAGES];
    logic             v_src   [STAGES];

    // Slice connections and next-state values.
    logic [CHUNK-1:0] sl_a    [STAGES];
    logic [CHUNK-1:0] sl_b    [STAGES];
    logic [CHUNK-1:0] sl_s    [STAGES];
    logic             sl_co   [STAGES];
    logic [WIDTH-1:0] sum_d   [STAGES];
    alu_flags_t       flags_d;

    alu_op_e          op_in;
    logic             stall;

    assign op_in     = alu_op_e'(sub);
    assign stall     = valid_q[STAGES-1] && !out_ready;
    assign in_ready  = !stall;

    assign out_valid = valid_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign cout      = flags_q.cout;
    assign ovf       = flags_q.ovf;
    assign zero      = flags_q.zero;

    // Stage inputs: stage 0 takes the port operands, with SUB folded in as
    // ~b and a forced carry of 1 (cin ignored); stage k takes stage k-1.
    // NOTE: every variable written in always_comb is assigned on every path
    // (here the loops cover every element) so no latch can be inferred.
    always_comb begin
        a_src[0]   = a;
        bp_src[0]  = (op_in == ALU_SUB) ? ~b : b;
        c_src[0]   = (op_in == ALU_SUB) ? 1'b1 : cin;
        sum_src[0] = '0;
        v_src[0]   = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_src[k]   = a_q[k-1];
            bp_src[k]  = bp_q[k-1];
            c_src[k]   = carry_q[k-1];
            sum_src[k] = sum_q[k-1];
            v_src[k]   = valid_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            sl_a[k] = a_src[k][k*CHUNK +: CHUNK];
            sl_b[k] = bp_src[k][k*CHUNK +: CHUNK];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        adder_slice #(
            .CHUNK (CHUNK)
        ) u_slice (
            .a_i (sl_a[k]),
            .b_i (sl_b[k]),
            .c_i (c_src[k]),
            .s_o (sl_s[k]),
            .c_o (sl_co[k])
        );
    end

    // Merge each slice's chunk into the partial sum; the last stage also
    // derives the flags from the fully assembled sum.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            sum_d[k]                    = sum_src[k];
            sum_d[k][k*CHUNK +: CHUNK]  = sl_s[k];
        end
        flags_d.cout = sl_co[STAGES-1];
        flags_d.ovf  = (a_src[STAGES-1][MSB] == bp_src[STAGES-1][MSB]) &&
                       (sum_d[STAGES-1][MSB] != a_src[STAGES-1][MSB]);
        flags_d.zero = ~|sum_d[STAGES-1];
    end

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its predecessor's pre-edge value.
    // NOTE: the stage data arrays are plain flops and are reset along with
    // the valid bits so sum and flags read 0 straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
                carry_q[k] <= 1'b0;
                a_q[k]     <= '0;
                bp_q[k]    <= '0;
                sum_q[k]   <= '0;
            end
            flags_q <= '0;
        end else if (!stall) begin
            // Bubbles advance like data; nothing is compressed.
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= v_src[k];
                carry_q[k] <= sl_co[k];
                a_q[k]     <= a_src[k];
                bp_q[k]    <= bp_src[k];
                sum_q[k]   <= sum_d[k];
            end
            flags_q <= flags_d;
        end
    end

endmodule

// File: tb/tb_pipe_adder.sv
// ---------------------------------------------------------------------------
// tb_pipe_adder
// Directed bench for pipe_adder: an 8-bit/2-stage instance for the
// functional, handshake and reset scenarios, and a 32-bit/4-stage instance
// for the wide wrap case plus a random valid/ready run against a model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pipe_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    // 8-bit, 2-stage instance
    logic       iv8, ir8, cin8, sub8, ov8, or8, cout8, ovf8, zero8;
    logic [7:0] a8, b8, sum8;

    // 32-bit, 4-stage instance
    logic        iv32, ir32, cin32, sub32, ov32, or32, cout32, ovf32, zero32;
    logic [31:0] a32, b32, sum32;

    pipe_adder #(.WIDTH(8), .STAGES(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .out_valid(ov8), .out_ready(or8),
        .sum(sum8), .cout(cout8), .ovf(ovf8), .zero(zero8)
    );

    pipe_adder #(.WIDTH(32), .STAGES(4)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32),
        .a(a32), .b(b32), .cin(cin32), .sub(sub32),
        .out_valid(ov32), .out_ready(or32),
        .sum(sum32), .cout(cout32), .ovf(ovf32), .zero(zero32)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        iv8  = 1'b0;
        iv32 = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drive8(input logic [7:0] ta, input logic [7:0] tb,
                          input logic tc, input logic ts, input logic tv);
        a8 = ta; b8 = tb; cin8 = tc; sub8 = ts; iv8 = tv;
    endtask

    // Launch one op on dut8 and wait (bounded) for its result.
    task automatic issue8(input logic [7:0] ta, input logic [7:0] tb,
                          input logic tc, input logic ts,
                          output logic [10:0] obs, output int lat);
        or8 = 1'b1;
        drive8(ta, tb, tc, ts, 1'b1);
        tick();
        iv8 = 1'b0;
        lat = 1;
        while (!ov8 && lat < 10) begin
            tick();
            lat++;
        end
        if (!ov8) lat = -1;
        obs = {sum8, cout8, ovf8, zero8};
    endtask

    task automatic issue32(input logic [31:0] ta, input logic [31:0] tb,
                           input logic tc, input logic ts,
                           output logic [34:0] obs, output int lat);
        or32 = 1'b1;
        a32 = ta; b32 = tb; cin32 = tc; sub32 = ts; iv32 = 1'b1;
        tick();
        iv32 = 1'b0;
        lat = 1;
        while (!ov32 && lat < 12) begin
            tick();
            lat++;
        end
        if (!ov32) lat = -1;
        obs = {sum32, cout32, ovf32, zero32};
    endtask

    // Reference: result and flags straight from the arithmetic definition.
    function automatic logic [34:0] model32(input logic [31:0] x, input logic [31:0] y,
                                            input logic c, input logic s);
        logic [31:0] yp;
        logic [32:0] full;
        yp   = s ? ~y : y;
        full = {1'b0, x} + {1'b0, yp} + {32'd0, (s ? 1'b1 : c)};
        return {full[31:0], full[32],
                (x[31] == yp[31]) && (full[31] != x[31]),
                full[31:0] == 32'd0};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({ov8, sum8, cout8, ovf8, zero8} !== 12'd0) begin
            errors++;
            $display("FAIL reset8: got %h, expected 000", {ov8, sum8, cout8, ovf8, zero8});
        end
        checks++;
        if ({ov32, sum32, cout32, ovf32, zero32} !== 36'd0) begin
            errors++;
            $display("FAIL reset32: got %h, expected 0", {ov32, sum32, cout32, ovf32, zero32});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if ({ir8, ir32, ov8, ov32} !== 4'b1100) begin
            errors++;
            $display("FAIL ready_after_reset: got %b, expected 1100", {ir8, ir32, ov8, ov32});
        end
    endtask

    task automatic test_add();
        logic [7:0]  ta [4] = '{8'h0F, 8'h7F, 8'hFF, 8'h0F};
        logic [7:0]  tb [4] = '{8'h01, 8'h01, 8'h01, 8'h00};
        logic        tc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [10:0] ex [4] = '{{8'h10, 3'b000}, {8'h80, 3'b010},
                                {8'h00, 3'b101}, {8'h10, 3'b000}};
        logic [10:0] obs;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            issue8(ta[i], tb[i], tc[i], 1'b0, obs, lat);
            checks++;
            if (lat != 2) begin
                errors++;
                $display("FAIL add_latency[%0d]: got %0d, expected 2", i, lat);
            end
            checks++;
            if (obs !== ex[i]) begin
                errors++;
                $display("FAIL add[%0d] {sum,c,v,z}: got %h, expected %h", i, obs, ex[i]);
            end
        end
    endtask

    task automatic test_sub();
        logic [7:0]  ta [5] = '{8'h05, 8'h80, 8'h05, 8'h80, 8'h05};
        logic [7:0]  tb [5] = '{8'h07, 8'h01, 8'h07, 8'h01, 8'h05};
        logic        tc [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [10:0] ex [5] = '{{8'hFE, 3'b000}, {8'h7F, 3'b110},
                                {8'hFE, 3'b000}, {8'h7F, 3'b110},
                                {8'h00, 3'b101}};
        logic [10:0] obs;
        int          lat;
        for (int i = 0; i < 5; i++) begin
            issue8(ta[i], tb[i], tc[i], 1'b1, obs, lat);
            checks++;
            if (lat != 2 || obs !== ex[i]) begin
                errors++;
                $display("FAIL sub[%0d] lat/{sum,c,v,z}: got %0d/%h, expected 2/%h",
                         i, lat, obs, ex[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  ta [4] = '{8'h01, 8'h10, 8'hF0, 8'h03};
        logic [7:0]  tb [4] = '{8'h02, 8'h20, 8'h10, 8'h01};
        logic        ts [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [10:0] ex [4] = '{{8'h03, 3'b000}, {8'h30, 3'b000},
                                {8'h00, 3'b101}, {8'h02, 3'b100}};
        idle(2);
        or8 = 1'b1;
        for (int t = 0; t < 7; t++) begin
            checks++;
            if (t >= 2 && t < 6) begin
                if ({ov8, sum8, cout8, ovf8, zero8} !== {1'b1, ex[t-2]}) begin
                    errors++;
                    $display("FAIL b2b[t=%0d] {v,sum,c,v,z}: got %h, expected %h",
                             t, {ov8, sum8, cout8, ovf8, zero8}, {1'b1, ex[t-2]});
                end
            end else if (ov8 !== 1'b0) begin
                errors++;
                $display("FAIL b2b_idle[t=%0d] out_valid: got %b, expected 0", t, ov8);
            end
            if (t < 4) drive8(ta[t], tb[t], 1'b0, ts[t], 1'b1);
            else       iv8 = 1'b0;
            tick();
        end
    endtask

    task automatic test_stall();
        logic [10:0] ex_a = {8'h33, 3'b000};
        logic [10:0] ex_b = {8'hFF, 3'b000};
        logic [10:0] ex_c = {8'hFF, 3'b010};
        idle(2);
        or8 = 1'b0;
        drive8(8'h11, 8'h22, 1'b0, 1'b0, 1'b1);   // A
        tick();
        drive8(8'h40, 8'h41, 1'b0, 1'b1, 1'b1);   // B
        tick();
        drive8(8'h7F, 8'h7F, 1'b1, 1'b0, 1'b1);   // C, held while stalled
        for (int t = 0; t < 3; t++) begin
            checks++;
            if ({ov8, ir8, sum8, cout8, ovf8, zero8} !== {2'b10, ex_a}) begin
                errors++;
                $display("FAIL stall_hold[%0d] {v,rdy,sum,c,v,z}: got %h, expected %h",
                         t, {ov8, ir8, sum8, cout8, ovf8, zero8}, {2'b10, ex_a});
            end
            tick();
        end
        or8 = 1'b1;
        #1;
        checks++;
        if ({ov8, ir8, sum8, cout8, ovf8, zero8} !== {2'b11, ex_a}) begin
            errors++;
            $display("FAIL stall_release {v,rdy,sum,c,v,z}: got %h, expected %h",
                     {ov8, ir8, sum8, cout8, ovf8, zero8}, {2'b11, ex_a});
        end
        tick();
        iv8 = 1'b0;
        checks++;
        if ({ov8, sum8, cout8, ovf8, zero8} !== {1'b1, ex_b}) begin
            errors++;
            $display("FAIL drain_b: got %h, expected %h", {ov8, sum8, cout8, ovf8, zero8}, {1'b1, ex_b});
        end
        tick();
        checks++;
        if ({ov8, sum8, cout8, ovf8, zero8} !== {1'b1, ex_c}) begin
            errors++;
            $display("FAIL drain_c: got %h, expected %h", {ov8, sum8, cout8, ovf8, zero8}, {1'b1, ex_c});
        end
        tick();
        checks++;
        if (ov8 !== 1'b0) begin
            errors++;
            $display("FAIL drain_dup out_valid: got %b, expected 0", ov8);
        end
    endtask

    task automatic test_async_reset();
        idle(2);
        or8 = 1'b1;
        drive8(8'h01, 8'h01, 1'b0, 1'b0, 1'b1);
        tick();
        drive8(8'h02, 8'h02, 1'b0, 1'b0, 1'b1);
        tick();
        iv8 = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ov8, ir8, sum8, cout8, ovf8, zero8} !== {2'b01, 11'd0}) begin
            errors++;
            $display("FAIL async_reset {v,rdy,sum,c,v,z}: got %h, expected %h",
                     {ov8, ir8, sum8, cout8, ovf8, zero8}, {2'b01, 11'd0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 4; t++) begin
            tick();
            checks++;
            if (ov8 !== 1'b0) begin
                errors++;
                $display("FAIL stale_after_reset[%0d] out_valid: got %b, expected 0", t, ov8);
            end
        end
    endtask

    task automatic test_wide();
        logic [31:0] ta [3] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        logic [31:0] tb [3] = '{32'h0000_0000, 32'h0000_0001, 32'h0000_0001};
        logic        tc [3] = '{1'b1, 1'b0, 1'b0};
        logic        ts [3] = '{1'b0, 1'b1, 1'b1};
        logic [34:0] ex [3] = '{{32'h0000_0000, 3'b101}, {32'hFFFF_FFFF, 3'b000},
                                {32'h7FFF_FFFF, 3'b110}};
        logic [34:0] obs;
        int          lat;
        for (int i = 0; i < 3; i++) begin
            issue32(ta[i], tb[i], tc[i], ts[i], obs, lat);
            checks++;
            if (lat != 4 || obs !== ex[i]) begin
                errors++;
                $display("FAIL wide[%0d] lat/{sum,c,v,z}: got %0d/%h, expected 4/%h",
                         i, lat, obs, ex[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [34:0] q[$];
        logic [34:0] exp_v;
        logic [34:0] held;
        logic        was_stalled;
        int          sent;
        int          cyc;
        idle(4);
        sent        = 0;
        cyc         = 0;
        was_stalled = 1'b0;
        held        = '0;
        while ((sent < 1000 || q.size() > 0) && cyc < 20000) begin
            if (was_stalled) begin
                checks++;
                if (!ov32 || {sum32, cout32, ovf32, zero32} !== held) begin
                    errors++;
                    $display("FAIL rand_stall_hold: got %b/%h, expected 1/%h",
                             ov32, {sum32, cout32, ovf32, zero32}, held);
                end
            end
            if (sent < 1000) begin
                iv32  = ($urandom_range(0, 3) != 0);
                a32   = $urandom;
                b32   = ($urandom_range(0, 7) == 0) ? ~a32 : $urandom;
                cin32 = 1'($urandom_range(0, 1));
                sub32 = 1'($urandom_range(0, 1));
            end else begin
                iv32 = 1'b0;
            end
            or32 = ($urandom_range(0, 3) != 0);
            #1;
            if (ov32 && or32) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_unexpected: got %h, expected no result",
                             {sum32, cout32, ovf32, zero32});
                end else begin
                    exp_v = q.pop_front();
                    if ({sum32, cout32, ovf32, zero32} !== exp_v) begin
                        errors++;
                        $display("FAIL rand_result: got %h, expected %h",
                                 {sum32, cout32, ovf32, zero32}, exp_v);
                    end
                end
            end
            was_stalled = ov32 && !or32;
            held        = {sum32, cout32, ovf32, zero32};
            if (iv32 && ir32) begin
                q.push_back(model32(a32, b32, cin32, sub32));
                sent++;
            end
            tick();
            cyc++;
        end
        checks++;
        if (sent != 1000 || q.size() != 0) begin
            errors++;
            $display("FAIL rand_complete: got sent=%0d pending=%0d, expected 1000/0",
                     sent, q.size());
        end
        iv32 = 1'b0;
    endtask

    initial begin
        iv8 = 0; cin8 = 0; sub8 = 0; or8 = 1; a8 = '0; b8 = '0;
        iv32 = 0; cin32 = 0; sub32 = 0; or32 = 1; a32 = '0; b32 = '0;
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_stall();
        test_async_reset();
        test_wide();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
